// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream instruction memory loader.
// Pulled in by the loader top and its byte assembler.
package imem_loader_pkg;

  localparam int ADDR_W_DEF     = 7;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_WRITE,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } ldr_state_t;

  function automatic logic state_takes_bytes(input ldr_state_t s);
    return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CHK);
  endfunction

  function automatic logic state_in_frame(input ldr_state_t s);
    return (s == ST_LOAD) || (s == ST_WRITE) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes into little-endian words; the first byte of a
// word ends up in bits [7:0].
module byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_done_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;

  // The completed word includes the byte being accepted this cycle.
  assign word_o      = {byte_i, sh_q[DATA_W-1:8]};
  assign word_done_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (shift_i) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = word_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: COUNT byte, 4*N little-endian payload bytes, XOR
// checksum byte. Writes words into IMEM and enables the CPU on a good frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic              reload_i,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_wen,
  output logic              enb,
  output logic              busy_o,
  output logic              err_o
);

  ldr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [7:0]        chk_q, chk_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wen_q, wen_d;
  logic              enb_q, enb_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              reload_act;
  logic              asm_clr;
  logic              asm_shift;
  logic [DATA_W-1:0] asm_word;
  logic              asm_done;

  assign accept     = byte_valid_i && ready_q;
  assign reload_act = reload_i && (state_q != ST_IDLE);

  byte_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (asm_clr),
    .shift_i     (asm_shift),
    .byte_i      (byte_data_i),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (reload_act) begin
      state_d = ST_HDR;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_HDR;
        ST_HDR:   if (accept) state_d = ST_LOAD;
        ST_LOAD:  if (asm_done) state_d = ST_WRITE;
        ST_WRITE: state_d = (addr_q == last_q) ? ST_CHK : ST_LOAD;
        ST_CHK:   if (accept) state_d = (byte_data_i == chk_q) ? ST_RUN : ST_ERR;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    addr_d    = addr_q;
    last_d    = last_q;
    chk_d     = chk_q;
    data_d    = data_q;
    wen_d     = 1'b0;
    enb_d     = enb_q;
    err_d     = err_q;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
    if (reload_act) begin
      // A byte accepted alongside reload is dropped on purpose.
      addr_d  = '0;
      chk_d   = '0;
      enb_d   = 1'b0;
      err_d   = 1'b0;
      asm_clr = 1'b1;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (accept) begin
            // COUNT of 0 wraps to the all-ones index, i.e. a full-depth image.
            last_d  = ADDR_W'(byte_data_i) - ADDR_W'(1);
            addr_d  = '0;
            chk_d   = '0;
            asm_clr = 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            asm_shift = 1'b1;
            chk_d     = chk_q ^ byte_data_i;
            if (asm_done) begin
              data_d = asm_word;
              wen_d  = 1'b1;
            end
          end
        end
        ST_WRITE: if (addr_q != last_q) addr_d = addr_q + ADDR_W'(1);
        ST_CHK: begin
          if (accept) begin
            if (byte_data_i == chk_q) enb_d = 1'b1;
            else                      err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    ready_d = state_takes_bytes(state_d);
    busy_d  = state_in_frame(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      last_q  <= '0;
      chk_q   <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      enb_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      last_q  <= last_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      enb_q   <= enb_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign inst_data    = data_q;
  assign inst_addr    = addr_q;
  assign inst_wen     = wen_q;
  assign enb          = enb_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, backpressure, bad checksum,
// reload, full-depth and mid-load reset scenarios.
module tb_imem_loader;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          reload = 1'b0;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_addr;
  logic          inst_wen;
  logic          enb;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:127];
  int          wen_cnt = 0;
  int          last_addr = -1;
  int          addr0_rewrites = 0;
  int          rdy_low = 0;
  bit          mon_en = 1'b0;
  logic        enb_before_chk;
  logic [7:0]  frame_q [$];

  imem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_data_i  (byte_data),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .reload_i     (reload),
    .inst_data    (inst_data),
    .inst_addr    (inst_addr),
    .inst_wen     (inst_wen),
    .enb          (enb),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // IMEM model: captures every strobe seen at a rising edge.
  always @(posedge clk) begin
    if (inst_wen === 1'b1) begin
      if (wen_cnt > 0 && inst_addr == '0) addr0_rewrites++;
      mem[inst_addr] = inst_data;
      wen_cnt++;
      last_addr = int'(inst_addr);
    end
  end

  always @(negedge clk) begin
    if (mon_en && byte_ready !== 1'b1) rdy_low++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD_BEEF;
    wen_cnt        = 0;
    last_addr      = -1;
    addr0_rewrites = 0;
    rdy_low        = 0;
    mon_en         = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst        = 1'b0;
    byte_valid = 1'b0;
    reload     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    @(negedge clk);
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) check("accept_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == frame_q.size() - 1) enb_before_chk = enb;
      send_byte(frame_q[i], gap);
      if (i == 0) mon_en = 1'b1;
    end
    mon_en     = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic load_nominal(input logic [7:0] chk);
    frame_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    frame_q.push_back(chk);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    #1;
    $display("case reset");
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_wen",   {31'd0, inst_wen}, 32'd0);
    check("rst_enb",   {31'd0, enb}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_addr",  32'(inst_addr), 32'd0);
    check("rst_data",  inst_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    #1 check("ready_before_edge", {31'd0, byte_ready}, 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", {31'd0, byte_ready}, 32'd1);

    $display("case nominal");
    load_nominal(8'h90);
    send_frame(1'b0);
    check("nom_mem0", mem[0], 32'h0000_0013);
    check("nom_mem1", mem[1], 32'h0010_0093);
    check("nom_wen_cnt", wen_cnt, 2);
    check("nom_enb_pre", {31'd0, enb_before_chk}, 32'd0);
    check("nom_enb", {31'd0, enb}, 32'd1);
    check("nom_err", {31'd0, err}, 32'd0);
    check("nom_rdy_low", rdy_low, 2);
    check("nom_last_addr", last_addr, 1);
    @(negedge clk);
    check("nom_run_ready", {31'd0, byte_ready}, 32'd0);
    check("nom_run_busy", {31'd0, busy}, 32'd0);

    $display("case backpressure");
    reset_dut();
    load_nominal(8'h90);
    send_frame(1'b1);
    check("bp_mem0", mem[0], 32'h0000_0013);
    check("bp_mem1", mem[1], 32'h0010_0093);
    check("bp_wen_cnt", wen_cnt, 2);
    check("bp_rdy_low", rdy_low, 2);
    check("bp_enb", {31'd0, enb}, 32'd1);

    $display("case bad checksum");
    reset_dut();
    load_nominal(8'h91);
    send_frame(1'b0);
    check("bad_wen_cnt", wen_cnt, 2);
    check("bad_mem1", mem[1], 32'h0010_0093);
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_enb", {31'd0, enb}, 32'd0);
    @(negedge clk);
    check("bad_ready", {31'd0, byte_ready}, 32'd0);
    pulse_reload();
    check("bad_rl_err", {31'd0, err}, 32'd0);
    check("bad_rl_ready", {31'd0, byte_ready}, 32'd1);
    check("bad_rl_busy", {31'd0, busy}, 32'd0);

    $display("case reload while running");
    reset_dut();
    load_nominal(8'h90);
    send_frame(1'b0);
    check("rl_enb_run", {31'd0, enb}, 32'd1);
    pulse_reload();
    check("rl_enb", {31'd0, enb}, 32'd0);
    check("rl_ready", {31'd0, byte_ready}, 32'd1);
    clear_model();
    mem[0] = 32'h0000_0013;
    frame_q = '{8'h01, 8'h37, 8'h00, 8'h00, 8'h00, 8'h37};
    send_frame(1'b0);
    check("rl_mem0", mem[0], 32'h0000_0037);
    check("rl_wen_cnt", wen_cnt, 1);
    check("rl_enb_new", {31'd0, enb}, 32'd1);

    $display("case full depth");
    reset_dut();
    frame_q = '{8'h00};
    for (int i = 0; i < 128; i++) begin
      frame_q.push_back(8'(i));
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
    end
    frame_q.push_back(8'h00);
    send_frame(1'b0);
    check("full_wen_cnt", wen_cnt, 128);
    check("full_last_addr", last_addr, 127);
    check("full_addr0_rewrites", addr0_rewrites, 0);
    check("full_mem64", mem[64], 32'd64);
    check("full_mem127", mem[127], 32'd127);
    check("full_enb", {31'd0, enb}, 32'd1);
    check("full_err", {31'd0, err}, 32'd0);

    $display("case reset mid-load");
    reset_dut();
    load_nominal(8'h90);
    for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1'b0);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst        = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("mid_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_wen",   {31'd0, inst_wen}, 32'd0);
    check("mid_addr",  32'(inst_addr), 32'd0);
    check("mid_data",  inst_data, 32'd0);
    check("mid_busy",  {31'd0, busy}, 32'd0);
    check("mid_enb",   {31'd0, enb}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    send_frame(1'b0);
    check("mid_mem0", mem[0], 32'h0000_0013);
    check("mid_mem1", mem[1], 32'h0010_0093);
    check("mid_wen_cnt", wen_cnt, 2);
    check("mid_enb_end", {31'd0, enb}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
